serial_add_unit: RTL and testbench

Bit-serial add/subtract engine for the ALU. It processes one operand bit per clock, LSB first, through a single `FULL_ADDER` instance and keeps the carry in a flip-flop. It is the sequential consumer of the full adder's `sum`/`cout` outputs and the area-minimal alternative to a ripple chain of `WIDTH` adders. Results are handed to the ALU result mux with a start/done handshake.

---
 rtl/serial_add_unit.sv | 195 +++++++++++++++++++
 tb/tb_serial_add_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_unit (with helper full_adder)
//  Description : Bit-serial add/subtract engine. One operand bit per clock,
//                LSB first, through a single full-adder cell; the carry
//                between bits is held in a flip-flop. The result is handed
//                off with a start/done handshake.
//
//  Optional feature macro: SERIAL_SUB_EN
//      defined   -> 'sub' port exists; subtraction = A + ~B + 1
//      undefined -> add-only, no 'sub' port, no B inversion logic
//
//  Ports:
//      clk     in   rising-edge clock
//      rst_n   in   asynchronous active-low reset
//      start   in   request an operation (honoured only in IDLE or DONE)
//      a, b    in   WIDTH-bit operands, captured on an accepted start
//      sub     in   1 = A - B, 0 = A + B (SERIAL_SUB_EN builds only)
//      busy    out  operation in progress
//      done    out  one-cycle pulse, result/flags valid
//      result  out  WIDTH-bit sum or difference
//      cout    out  final carry out (subtract: 1 = no borrow)
//      ovf     out  signed overflow (carry into MSB ^ carry out of MSB)
//      zero    out  result == 0
//
//  Revision    : 1.0  initial release
// ============================================================================

// Single-bit full adder cell used by the serial engine.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // One spare counter bit so the count can reach WIDTH without wrapping.
    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_seed;

    // ------------------------------------------------------------------
    // Operand B conditioning and carry seed. Subtraction is done as
    // A + ~B + 1, the +1 entering through the initial carry.
    // ------------------------------------------------------------------
`ifdef SERIAL_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_seed = sub;
`else
    assign w_b_load     = b;
    assign w_carry_seed = 1'b0;
`endif

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == c_last);
    // Carry entering the MSB is the carry register during the last bit.
    assign w_msb_cin = r_carry;

    full_adder u_full_adder (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                // start is deliberately ignored here: no queueing.
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A start in the done cycle launches the next operation
                // directly, giving one result per WIDTH+1 cycles.
                w_state_nxt = start ? S_SHIFT : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shift registers, carry, counter, result, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Result and flags are left untouched so they stay valid
            // until the first shift of the new operation.
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_carry_seed;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_result <= {w_fa_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_fa_cout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_fa_cout;
                r_ovf  <= w_msb_cin ^ w_fa_cout;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_add_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_unit
//  Description : Self-checking bench for serial_add_unit. Directed cases plus
//                randomized operands checked against an arithmetic reference
//                model. Subtraction cases are included when SERIAL_SUB_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_vec;
    int n_err;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, output logic [W-1:0] r,
                                  output logic c, output logic v);
        longint ua, ub, u, sa, sb, s;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
        sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
        if (ms) begin
            u = ua + ((longint'(1) << W) - 1 - ub) + 1;
            s = sa - sb;
        end else begin
            u = ua + ub;
            s = sa + sb;
        end
        r = W'(u);
        c = u[W];
        v = (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
    endfunction

    // Launch one operation from an idle/done point (called #1 after an edge)
    // and wait, bounded, for done. lat = edges after the start edge until
    // done is seen (-1 on timeout); nbusy = cycles busy was seen high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, output int lat, output int nbusy);
        a     = ta;
        b     = tb;
        sub   = ts;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        nbusy = busy ? 1 : 0;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (result !== '0)  begin n_err++; $display("FAIL reset_result: got %h want 00", result); end
        n_vec++; if (cout !== 1'b0)  begin n_err++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_vec++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_vec++; if (zero !== 1'b1)  begin n_err++; $display("FAIL reset_zero: got %b want 1", zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Directed cases with hand-derived expectations.
    task automatic test_directed;
        logic [W-1:0] da [6];
        logic [W-1:0] db [6];
        logic         ds [6];
        logic [W-1:0] er [6];
        logic         ec [6];
        logic         ev [6];
        int           ncase;
        int           lat, nb;
        da[0] = 8'h03; db[0] = 8'h05; ds[0] = 1'b0; er[0] = 8'h08; ec[0] = 1'b0; ev[0] = 1'b0;
        da[1] = 8'hFF; db[1] = 8'h01; ds[1] = 1'b0; er[1] = 8'h00; ec[1] = 1'b1; ev[1] = 1'b0;
        da[2] = 8'h7F; db[2] = 8'h01; ds[2] = 1'b0; er[2] = 8'h80; ec[2] = 1'b0; ev[2] = 1'b1;
        da[3] = 8'h80; db[3] = 8'h80; ds[3] = 1'b0; er[3] = 8'h00; ec[3] = 1'b1; ev[3] = 1'b1;
        da[4] = 8'h05; db[4] = 8'h03; ds[4] = 1'b1; er[4] = 8'h02; ec[4] = 1'b1; ev[4] = 1'b0;
        da[5] = 8'h03; db[5] = 8'h05; ds[5] = 1'b1; er[5] = 8'hFE; ec[5] = 1'b0; ev[5] = 1'b0;
`ifdef SERIAL_SUB_EN
        ncase = 6;
`else
        ncase = 4;
`endif
        for (int i = 0; i < ncase; i++) begin
            run_op(da[i], db[i], ds[i], lat, nb);
            n_vec++; if (lat !== W)  begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
            n_vec++; if (nb !== W)   begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, nb, W); end
            n_vec++; if (result !== er[i]) begin n_err++; $display("FAIL dir%0d_result: got %h want %h", i, result, er[i]); end
            n_vec++; if (cout !== ec[i])   begin n_err++; $display("FAIL dir%0d_cout: got %b want %b", i, cout, ec[i]); end
            n_vec++; if (ovf !== ev[i])    begin n_err++; $display("FAIL dir%0d_ovf: got %b want %b", i, ovf, ev[i]); end
            n_vec++; if (zero !== (er[i] == '0)) begin n_err++; $display("FAIL dir%0d_zero: got %b want %b", i, zero, (er[i] == '0)); end
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
            n_vec++; if (result !== er[i]) begin n_err++; $display("FAIL dir%0d_result_hold: got %h want %h", i, result, er[i]); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, er;
        logic         rs, ec, ev;
        int           lat, nb;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            model(ra, rb, rs, er, ec, ev);
            run_op(ra, rb, rs, lat, nb);
            n_vec++; if (lat !== W) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, W); end
            n_vec++; if (result !== er) begin n_err++; $display("FAIL rnd%0d_result a=%h b=%h s=%b: got %h want %h", i, ra, rb, rs, result, er); end
            n_vec++; if (cout !== ec)   begin n_err++; $display("FAIL rnd%0d_cout: got %b want %b", i, cout, ec); end
            n_vec++; if (ovf !== ev)    begin n_err++; $display("FAIL rnd%0d_ovf: got %b want %b", i, ovf, ev); end
            n_vec++; if (zero !== (er == '0)) begin n_err++; $display("FAIL rnd%0d_zero: got %b want %b", i, zero, (er == '0)); end
            // Alternate between returning to idle and idling extra cycles.
            repeat (i % 3) begin @(posedge clk); #1; end
        end
    endtask

    // start during SHIFT is dropped; start in the done cycle chains.
    task automatic test_back_to_back;
        int lat;
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;              // start edge T
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;              // T+2, mid SHIFT
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;              // T+3, must be ignored
        start = 1'b0;
        lat = -1;
        for (int k = 4; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_vec++; if (lat !== W) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", lat, W); end
        n_vec++; if (result !== 8'h30) begin n_err++; $display("FAIL ignore_result: got %h want 30", result); end
        // Now in the done cycle: chain a new operation.
        a = 8'h21; b = 8'h12; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_low: got %b want 0", done); end
        lat = -1;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        n_vec++; if (lat !== W) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, W); end
        n_vec++; if (result !== 8'h33) begin n_err++; $display("FAIL b2b_result: got %h want 33", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int lat, nb, ndone;
        a = 8'hA5; b = 8'h3C; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (result !== '0)  begin n_err++; $display("FAIL midrst_result: got %h want 00", result); end
        n_vec++; if (zero !== 1'b1)  begin n_err++; $display("FAIL midrst_zero: got %b want 1", zero); end
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d activity cycles want 0", ndone); end
        run_op(8'h44, 8'h55, 1'b0, lat, nb);
        n_vec++; if (lat !== W) begin n_err++; $display("FAIL postrst_latency: got %0d want %0d", lat, W); end
        n_vec++; if (result !== 8'h99) begin n_err++; $display("FAIL postrst_result: got %h want 99", result); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL postrst_ovf: got %b want 1", ovf); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
